// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin burst arbiter in front of a FIFO write port.
// One grant per burst; each beat is written whenever the FIFO is not full.
module fifo_wr_arb #(
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic [DW-1:0] DATAIN0,
    input  logic [DW-1:0] DATAIN1,
    input  logic          full,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic          last,
    output logic          wn,
    output logic [DW-1:0] DATAOUT
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state_q, state_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          lsrv_q, lsrv_d;
    logic          win1;

    // lsrv_q is the requester served last; a tie goes to the other one.
    assign win1 = req1 && (!req0 || !lsrv_q);

    always_comb begin
        state_d = state_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        cnt_d   = cnt_q;
        lsrv_d  = lsrv_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BURST;
                    gnt0_d  = !win1;
                    gnt1_d  = win1;
                    cnt_d   = win1 ? len1 : len0;
                    lsrv_d  = win1;
                end
            end
            BURST: begin
                if (!full) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
            lsrv_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            cnt_q   <= cnt_d;
            lsrv_q  <= lsrv_d;
        end
    end

    always_comb begin
        wn      = (state_q == BURST) && !full;
        ack0    = wn && gnt0_q;
        ack1    = wn && gnt1_q;
        last    = wn && (cnt_q == '0);
        DATAOUT = '0;
        if (state_q == BURST) begin
            DATAOUT = gnt1_q ? DATAIN1 : DATAIN0;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DW, default 8, data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter LW, default 4, width of burst-length fields; burst beats = len+1 (1..2^LW).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0, req1  input  1 each  burst request from requester 0 / 1.
REQ-006 SHALL have ports len0, len1  input  LW each  burst length minus one, sampled only at grant.
REQ-007 SHALL have ports DATAIN0, DATAIN1  input  DW each  write data from requester 0 / 1.
REQ-008 SHALL have port full  input  1  FIFO full flag.
REQ-009 SHALL have ports gnt0, gnt1  output  1 each  registered; high for the whole burst owned by that requester.
REQ-010 SHALL have ports ack0, ack1  output  1 each  combinational; high in a cycle where that requester's beat is written.
REQ-011 SHALL have port last  output  1  combinational; high with the ack of the final beat of a burst.
REQ-012 SHALL have port wn  output  1  combinational FIFO write enable.
REQ-013 SHALL have port DATAOUT  output  DW  combinational FIFO write data.

Function
REQ-014 SHALL implement two states: IDLE and BURST.
REQ-015 IDLE: at a clock edge with any req high, SHALL select a winner, load beat counter with the winner's len, set the winner's gnt, and enter BURST; with no req, remain IDLE.
REQ-016 Arbitration SHALL be round-robin: single requester wins outright; with both high, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-017 The last-served pointer SHALL update at grant time.
REQ-018 BURST: wn SHALL equal !full; DATAOUT SHALL equal DATAIN of the granted requester; ack of the granted requester SHALL equal wn; the other ack SHALL be 0.
REQ-019 In IDLE, wn, ack0, ack1 and last SHALL be 0 and DATAOUT SHALL be 0.
REQ-020 Each accepted beat (wn high) SHALL decrement the counter; with full high the counter, gnt and state SHALL hold (stall, no beat lost).
REQ-021 last SHALL be high when wn is high and the counter equals 0; at that edge the state SHALL return to IDLE and both gnt SHALL clear.
REQ-022 Minimum spacing SHALL be one IDLE cycle between consecutive bursts (grant latency: req sampled at edge N, gnt high after N, first beat possible in cycle after N).
REQ-023 req and len changes during BURST SHALL be ignored; the burst always completes with len+1 beats.
REQ-024 gnt0 and gnt1 SHALL never be high together; at most one ack SHALL be high per cycle.
REQ-025 Counter arithmetic SHALL be LW bits, unsigned; len = 2^LW-1 SHALL yield 2^LW beats with no wrap error.

Reset
REQ-026 On reset high, asynchronously: state IDLE, gnt0=gnt1=0, counter=0, last-served pointer = requester 1 (so requester 0 wins first tie); consequently wn, ack0, ack1, last, DATAOUT = 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; no further wn until a new grant after reset release.

Verification
REQ-028 Single burst: req0=1, len0=3, full=0, DATAIN0 = A0..A3 -> gnt0 next cycle, wn/ack0 four consecutive cycles, last on 4th, gnt0 low after.
REQ-029 Tie: req0=req1=1 from reset, len0=len1=1 -> order gnt0 (2 beats), 1 idle cycle, gnt1 (2 beats), 1 idle cycle, gnt0.
REQ-030 Stall: burst len0=2, full=1 during beat 2 for 3 cycles -> wn=0, ack0=0 those cycles, counter holds, exactly 3 beats written total.
REQ-031 Max length: len1=2^LW-1 (15) -> exactly 16 beats, last on 16th only.
REQ-032 Reset mid-burst: assert reset after 2 of 5 beats -> gnt0, wn drop immediately (asynchronous); after release with req1 only -> gnt1 granted.
REQ-033 Mid-burst request change: req0 drops and len0 changes after grant -> burst still delivers original len0+1 beats.
